// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO timer peripheral: register offsets,
// TCON bit positions, default base address and the decoded-register select.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_DIGI    = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_DIGI,
    SEL_SYSTICK
  } reg_sel_e;

endpackage

// File: rtl/mmio_reload_timer.sv
// Reload timer: prescaler, TH/TL/TCON registers and registered interrupt.
// TL counts up on each prescaler tick and reloads from TH after 32'hFFFFFFFF.
module mmio_reload_timer
  import mmio_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] pcnt;
  logic        tick;
  logic        overflow;
  logic        st_set;

  // Tick when the prescaler wraps; EN is sampled before any same-cycle write.
  always_comb begin
    tick     = tcon[TCON_EN] && (pcnt == PS_LAST);
    overflow = tick && (tl == '1);
    st_set   = overflow && tcon[TCON_IE];
  end

  // Prescaler: counts while enabled, parked at zero while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (!tcon[TCON_EN] || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end

  // TH/TL: CPU write to TL beats a tick; reload reads TH before any same-cycle write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th <= '0;
      tl <= '0;
    end else begin
      if (wr_th) th <= wdata;
      if (wr_tl) begin
        tl <= wdata;
      end else if (tick) begin
        tl <= overflow ? th : tl + 32'd1;
      end
    end
  end

  // TCON and irq: setting ST takes priority over its write-1-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcon <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_tcon) begin
        tcon[TCON_EN] <= wdata[TCON_EN];
        tcon[TCON_IE] <= wdata[TCON_IE];
      end
      if (st_set) begin
        tcon[TCON_ST] <= 1'b1;
      end else if (wr_tcon && wdata[TCON_ST]) begin
        tcon[TCON_ST] <= 1'b0;
      end
      irq <= tcon[TCON_IE] & tcon[TCON_ST];
    end
  end

endmodule

// File: rtl/mmio_timer_periph.sv
// Memory-mapped peripheral on the CPU data bus: reload timer, LED and digit
// registers, and an optional free-running SYSTICK counter (MMIO_SYSTICK_EN).
module mmio_timer_periph
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned DIGI_W    = 12,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Address,
  input  logic [31:0]       Write_data,
  output logic [31:0]       Read_data,
  output logic              hit,
  output logic              irq,
  output logic [LED_W-1:0]  leds,
  output logic [DIGI_W-1:0] digi
);

  reg_sel_e    sel;
  logic        wr;
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^Address[1:0];

  // Address decode; word offset only, byte lane bits ignored.
  always_comb begin
    sel = SEL_NONE;
    if (Address[31:5] == BASE_ADDR[31:5]) begin
      case ({Address[4:2], 2'b00})
        OFF_TH:      sel = SEL_TH;
        OFF_TL:      sel = SEL_TL;
        OFF_TCON:    sel = SEL_TCON;
        OFF_LED:     sel = SEL_LED;
        OFF_DIGI:    sel = SEL_DIGI;
`ifdef MMIO_SYSTICK_EN
        OFF_SYSTICK: sel = SEL_SYSTICK;
`endif
        default:     sel = SEL_NONE;
      endcase
    end
  end

  assign hit = (sel != SEL_NONE);
  assign wr  = hit && MemWrite;

`ifdef MMIO_SYSTICK_EN
  logic [31:0] systick;

  // Free-running cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) systick <= '0;
    else        systick <= systick + 32'd1;
  end
`endif

  // Combinational read mux; zero unless a mapped register is read.
  always_comb begin
    Read_data = '0;
    if (hit && MemRead) begin
      case (sel)
        SEL_TH:      Read_data = th;
        SEL_TL:      Read_data = tl;
        SEL_TCON:    Read_data = 32'(tcon);
        SEL_LED:     Read_data = 32'(leds);
        SEL_DIGI:    Read_data = 32'(digi);
`ifdef MMIO_SYSTICK_EN
        SEL_SYSTICK: Read_data = systick;
`endif
        default:     Read_data = '0;
      endcase
    end
  end

  // LED and digit output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds <= '0;
      digi <= '0;
    end else begin
      if (wr && sel == SEL_LED)  leds <= Write_data[LED_W-1:0];
      if (wr && sel == SEL_DIGI) digi <= Write_data[DIGI_W-1:0];
    end
  end

  mmio_reload_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .wr_th  (wr && sel == SEL_TH),
    .wr_tl  (wr && sel == SEL_TL),
    .wr_tcon(wr && sel == SEL_TCON),
    .wdata  (Write_data),
    .th     (th),
    .tl     (tl),
    .tcon   (tcon),
    .irq    (irq)
  );

endmodule
